nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
Multi-cycle W-bit adder (W = 4*NIBBLES) built around one instance of the team's 4-bit carry_lookahead_adder (ports a, b, cin, sum, cout).
- Accepts a full-width operand pair over a valid/ready handshake.
- Feeds the CLA one nibble per cycle, LSB nibble first, and registers the ripple carry between nibbles.
- Returns the full sum, carry-out and signed-overflow flag over a second valid/ready handshake.
- Sits directly upstream of, and consumes, the 4-bit CLA.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
clk        input   1   clock; all state updates on rising edge
rst        input   1   asynchronous, active-high reset
in_valid   input   1   operand pair and cin valid
in_ready   output  1   block can accept an operand pair
a          input   W   operand A (unsigned or two's complement)
b          input   W   operand B
cin        input   1   carry into bit 0
out_valid  output  1   result valid
out_ready  input   1   consumer accepts result
sum        output  W   a + b + cin, modulo 2^W
cout       output  1   carry out of bit W-1
ovf        output  1   signed overflow: a[W-1]==b[W-1] and sum[W-1]!=a[W-1]
busy       output  1   high in ADD or DONE

Behaviour:
- Reset: already decided. One clock, clk. rst is asynchronous and active-high. While rst=1 and on its assertion:
  - state=IDLE.
  - in_ready=1 after reset.
  - out_valid=0, busy=0.
  - sum=0, cout=0, ovf=0.
  - Internal shift registers, carry register and nibble counter are all 0.
- FSM states: IDLE, ADD, DONE.
  - in_ready = (state==IDLE), combinational from state.
  - out_valid = (state==DONE).
  - busy = (state!=IDLE).
- IDLE, on in_valid && in_ready at edge k:
  - Latch a, b into shift registers a_sh, b_sh.
  - carry_reg <= cin; latch a[W-1] and b[W-1] for ovf.
  - idx <= 0; go to ADD.
  - in_valid without in_ready is ignored; inputs are not sampled.
- ADD, each cycle:
  - CLA inputs: a_sh[3:0], b_sh[3:0], carry_reg.
  - At the edge: sum_sh shifts right 4 with the CLA sum entering bits [W-1:W-4].
  - a_sh and b_sh shift right 4; carry_reg <= CLA cout; idx++.
  - When idx==NIBBLES-1 at the edge: go to DONE. Register sum <= final sum_sh value, cout <= CLA cout, ovf per formula.
- Latency: out_valid rises after edge k+NIBBLES, i.e. NIBBLES cycles after the accepting edge.
- DONE:
  - sum, cout and ovf are held stable while out_valid=1 && out_ready=0. Unbounded backpressure is allowed.
  - On out_valid && out_ready: go to IDLE. sum, cout and ovf keep their last values; they are don't-care once out_valid=0.
- Throughput: one operation per NIBBLES+2 cycles minimum. No overlap; a new accept occurs no earlier than the cycle after handoff.
- Arithmetic: result = (a + b + cin) mod 2^W; cout is bit W of the true sum.
  - Boundary: all-ones + all-ones + 1 gives sum all-ones with cout=1.
  - Zero + zero + 0 gives sum 0 with cout=0 and ovf=0.
- NIBBLES=1: a single ADD cycle, then DONE.
- Reset mid-operation (ADD or DONE): abort immediately, return to reset values, and emit no result. The first accept after reset deassertion behaves normally.
- Operand inputs may change freely after acceptance; they do not affect the result in flight.

Test Plan:
1. NIBBLES=4, reset then a=0x1234, b=0x4321, cin=0, out_ready=1 -> in_ready drops the next cycle; out_valid rises exactly 4 cycles after accept with sum=0x5555, cout=0, ovf=0; in_ready returns the cycle after handoff.
2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0 (carry ripples through all four nibbles).
3. a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1, ovf=1.
4. Backpressure: a=0x00F0, b=0x0F10, cin=1 with out_ready=0 for 6 cycles after out_valid -> sum=0x1001 held stable, out_valid held, in_ready=0. A pulse of in_valid with a=0xAAAA during this time is ignored; releasing out_ready hands off once.
5. Reset mid-op: accept a=0x1111, b=0x2222, then assert rst asynchronously during the 2nd ADD cycle -> out_valid, sum, cout and busy go to 0 immediately, in_ready=1 after release. The next op a=0x0003, b=0x0004, cin=0 -> sum=0x0007.
6. Random regression: 1000 random a, b, cin with random out_ready stalls, for NIBBLES=1 and NIBBLES=4 -> every result matches the reference model (a+b+cin) and the ovf formula; no result is lost or duplicated.

Source files
------------

// File: rtl/nibble_serial_adder_if.sv
// Handshake bundle for nibble_serial_adder: operand request, result response and status.
// The master side drives operands and out_ready; the slave side is the adder.
interface nibble_serial_adder_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         busy;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, busy
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf, busy
   );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder: one 4-bit carry-lookahead slice reused LSB nibble first,
// with the ripple carry registered between nibbles and a valid/ready result port.
module carry_lookahead_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
      sum  = p ^ c[3:0];
      cout = c[4];
   end
endmodule

module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input logic                  clk,
   input logic                  rst,
   nibble_serial_adder_if.slave bus
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  a_sh_q, a_sh_d;
   logic [W-1:0]  b_sh_q, b_sh_d;
   logic [W-1:0]  sum_sh_q, sum_sh_d;
   logic          carry_q, carry_d;
   logic          a_msb_q, a_msb_d;
   logic          b_msb_q, b_msb_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [W-1:0]  sum_q, sum_d;
   logic          cout_q, cout_d;
   logic          ovf_q, ovf_d;

   logic [3:0]    cla_sum;
   logic          cla_cout;
   logic [W+3:0]  sum_cat;

   carry_lookahead_adder u_cla (
      .a    (a_sh_q[3:0]),
      .b    (b_sh_q[3:0]),
      .cin  (carry_q),
      .sum  (cla_sum),
      .cout (cla_cout)
   );

   // Concatenate then drop the low nibble so the shift also works when W == 4.
   assign sum_cat = {cla_sum, sum_sh_q};

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      carry_d  = carry_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      idx_d    = idx_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               a_sh_d   = bus.a;
               b_sh_d   = bus.b;
               sum_sh_d = '0;
               carry_d  = bus.cin;
               a_msb_d  = bus.a[W-1];
               b_msb_d  = bus.b[W-1];
               idx_d    = '0;
               state_d  = ST_ADD;
            end
         end
         ST_ADD: begin
            sum_sh_d = sum_cat[W+3:4];
            a_sh_d   = a_sh_q >> 4;
            b_sh_d   = b_sh_q >> 4;
            carry_d  = cla_cout;
            idx_d    = idx_q + IW'(1);
            if (idx_q == IW'(NIBBLES - 1)) begin
               sum_d   = sum_cat[W+3:4];
               cout_d  = cla_cout;
               ovf_d   = (a_msb_q == b_msb_q) && (cla_sum[3] != a_msb_q);
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         carry_q  <= 1'b0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         idx_q    <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         carry_q  <= carry_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         idx_q    <= idx_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at NIBBLES=4 and NIBBLES=1.
// Stimulus pushes expected results; negedge monitors pop them at each handoff.
module tb_nibble_serial_adder;
   logic clk = 1'b0;
   logic rst;
   bit   rnd_en = 1'b0;

   always #5 clk = ~clk;

   nibble_serial_adder_if #(.NIBBLES(4)) ifc ();
   nibble_serial_adder_if #(.NIBBLES(1)) ifc1 ();

   nibble_serial_adder #(.NIBBLES(4)) dut (.clk(clk), .rst(rst), .bus(ifc));
   nibble_serial_adder #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1));

   typedef struct packed {
      logic [15:0] s;
      logic        c;
      logic        o;
   } exp_t;

   exp_t q4[$];
   exp_t q1[$];
   int   tests = 0;
   int   fails = 0;
   int   hand4 = 0;
   int   hand1 = 0;
   int   issued4 = 0;
   int   issued1 = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic note_fail(input string name);
      tests++;
      fails++;
      $display("FAIL %s: bound expired or unexpected event", name);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && ifc.out_valid && ifc.out_ready) begin
         hand4++;
         if (q4.size() == 0) note_fail("result4_unexpected");
         else begin
            e = q4.pop_front();
            check("sum4", 32'(ifc.sum), 32'(e.s));
            check("cout4", 32'(ifc.cout), 32'(e.c));
            check("ovf4", 32'(ifc.ovf), 32'(e.o));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst && ifc1.out_valid && ifc1.out_ready) begin
         hand1++;
         if (q1.size() == 0) note_fail("result1_unexpected");
         else begin
            e = q1.pop_front();
            check("sum1", 32'(ifc1.sum), 32'(e.s));
            check("cout1", 32'(ifc1.cout), 32'(e.c));
            check("ovf1", 32'(ifc1.ovf), 32'(e.o));
         end
      end
   end

   always @(posedge clk) begin
      if (rnd_en) begin
         #1;
         ifc.out_ready  = 1'($urandom_range(0, 1));
         ifc1.out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
   task automatic issue4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [15:0] es, input logic ec, input logic eo, input bit push);
      int n = 0;
      while (!ifc.in_ready && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      if (!ifc.in_ready) begin
         note_fail("in_ready4_timeout");
         return;
      end
      ifc.in_valid = 1'b1;
      ifc.a        = a;
      ifc.b        = b;
      ifc.cin      = cin;
      if (push) begin
         q4.push_back({es, ec, eo});
         issued4++;
      end
      @(posedge clk); #1;
      ifc.in_valid = 1'b0;
      ifc.a        = 16'($urandom);
      ifc.b        = 16'($urandom);
      ifc.cin      = 1'($urandom_range(0, 1));
   endtask

   task automatic issue1(input logic [3:0] a, input logic [3:0] b, input logic cin,
                         input logic [3:0] es, input logic ec, input logic eo);
      int n = 0;
      while (!ifc1.in_ready && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      if (!ifc1.in_ready) begin
         note_fail("in_ready1_timeout");
         return;
      end
      ifc1.in_valid = 1'b1;
      ifc1.a        = a;
      ifc1.b        = b;
      ifc1.cin      = cin;
      q1.push_back({12'h000, es, ec, eo});
      issued1++;
      @(posedge clk); #1;
      ifc1.in_valid = 1'b0;
      ifc1.a        = 4'($urandom);
      ifc1.b        = 4'($urandom);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((ifc.busy || ifc1.busy || q4.size() != 0 || q1.size() != 0) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 2000) note_fail(name);
   endtask

   initial begin
      int h;
      int n;
      logic [15:0] ra, rb;
      logic        rc;
      logic [16:0] full;
      logic [3:0]  sa, sb;
      logic [4:0]  full1;

      rst            = 1'b1;
      ifc.in_valid   = 1'b0;
      ifc.a          = '0;
      ifc.b          = '0;
      ifc.cin        = 1'b0;
      ifc.out_ready  = 1'b1;
      ifc1.in_valid  = 1'b0;
      ifc1.a         = '0;
      ifc1.b         = '0;
      ifc1.cin       = 1'b0;
      ifc1.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      check("rst_in_ready", 32'(ifc.in_ready), 32'd1);
      check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
      check("rst_busy", 32'(ifc.busy), 32'd0);
      check("rst_sum", 32'(ifc.sum), 32'd0);
      check("rst_cout", 32'(ifc.cout), 32'd0);
      check("rst_ovf", 32'(ifc.ovf), 32'd0);

      // Latency and handshake timing.
      issue4(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
      check("t1_in_ready_low", 32'(ifc.in_ready), 32'd0);
      check("t1_busy", 32'(ifc.busy), 32'd1);
      repeat (3) begin @(posedge clk); #1; end
      check("t1_not_yet_valid", 32'(ifc.out_valid), 32'd0);
      @(posedge clk); #1;
      check("t1_out_valid", 32'(ifc.out_valid), 32'd1);
      @(posedge clk); #1;
      check("t1_in_ready_back", 32'(ifc.in_ready), 32'd1);
      check("t1_out_valid_low", 32'(ifc.out_valid), 32'd0);

      issue4(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      issue4(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);
      issue4(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
      issue4(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
      issue4(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      wait_idle("t2_drain");

      // Backpressure with an ignored in_valid pulse.
      ifc.out_ready = 1'b0;
      issue4(16'h00F0, 16'h0F10, 1'b1, 16'h1001, 1'b0, 1'b0, 1'b1);
      n = 0;
      while (!ifc.out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!ifc.out_valid) note_fail("t4_out_valid_timeout");
      for (int i = 0; i < 6; i++) begin
         check("t4_hold_valid", 32'(ifc.out_valid), 32'd1);
         check("t4_hold_sum", 32'(ifc.sum), 32'h1001);
         check("t4_hold_in_ready", 32'(ifc.in_ready), 32'd0);
         if (i == 2) begin
            ifc.in_valid = 1'b1;
            ifc.a        = 16'hAAAA;
            ifc.b        = 16'h1111;
         end
         if (i == 3) ifc.in_valid = 1'b0;
         @(posedge clk); #1;
      end
      h = hand4;
      ifc.out_ready = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      check("t4_single_handoff", 32'(hand4), 32'(h + 1));
      check("t4_no_phantom_op", 32'(ifc.busy), 32'd0);

      // Asynchronous reset during the second ADD cycle.
      issue4(16'h1111, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #2;
      check("t5_busy_before", 32'(ifc.busy), 32'd1);
      rst = 1'b1;
      #1;
      check("t5_out_valid", 32'(ifc.out_valid), 32'd0);
      check("t5_sum", 32'(ifc.sum), 32'd0);
      check("t5_cout", 32'(ifc.cout), 32'd0);
      check("t5_busy", 32'(ifc.busy), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("t5_in_ready", 32'(ifc.in_ready), 32'd1);
      issue4(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b1);
      wait_idle("t5_drain");

      // Single-slice build.
      issue1(4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0);
      issue1(4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
      issue1(4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
      wait_idle("n1_drain");

      rnd_en = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         ra   = 16'($urandom);
         rb   = 16'($urandom);
         rc   = 1'($urandom_range(0, 1));
         full = {1'b0, ra} + {1'b0, rb} + 17'(rc);
         issue4(ra, rb, rc, full[15:0], full[16], (ra[15] == rb[15]) && (full[15] != ra[15]), 1'b1);
      end
      for (int i = 0; i < 1000; i++) begin
         sa    = 4'($urandom);
         sb    = 4'($urandom);
         rc    = 1'($urandom_range(0, 1));
         full1 = {1'b0, sa} + {1'b0, sb} + 5'(rc);
         issue1(sa, sb, rc, full1[3:0], full1[4], (sa[3] == sb[3]) && (full1[3] != sa[3]));
      end
      rnd_en = 1'b0;
      @(posedge clk); #2;
      ifc.out_ready  = 1'b1;
      ifc1.out_ready = 1'b1;
      @(posedge clk); #1;
      wait_idle("rand_drain");

      check("handoffs4", 32'(hand4), 32'(issued4));
      check("handoffs1", 32'(hand1), 32'(issued1));
      check("q4_empty", 32'(q4.size()), 32'd0);
      check("q1_empty", 32'(q1.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
